// File: rtl/dsp_mem_loader_if.sv
// Boot-stream and memory-write bundle between the upstream byte source, the loader and the dsp memories.
// The slave modport is the loader's view; master is the upstream/memory side.
interface dsp_mem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we_instr;
  logic              mem_we_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_addr,
    output mem_wdata,
    output mem_we_instr,
    output mem_we_data
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we_instr,
    input  mem_we_data
  );
endinterface

// File: rtl/dsp_mem_loader.sv
// Framed byte-stream boot loader: assembles big-endian words, writes them into InstrMem/DataMem
// through registered one-cycle strobes, and releases the dsp core once the end-of-load command arrives.
module dsp_mem_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  dsp_mem_loader_if.slave     bus,
  output logic [15:0]         words_written,
  output logic                dsp_run,
  output logic                err
);

  localparam logic [7:0] CMD_INSTR = 8'hA5;
  localparam logic [7:0] CMD_DATA  = 8'h5A;
  localparam logic [7:0] CMD_END   = 8'hF0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    CNT_H,
    CNT_L,
    DATA_H,
    DATA_L,
    DONE,
    ERR
  } state_t;

  state_t              state_q,     state_d;
  logic                toInstr_q,   toInstr_d;
  logic [7:0]          addrHi_q,    addrHi_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [7:0]          cntHi_q,     cntHi_d;
  logic [15:0]         cnt_q,       cnt_d;
  logic [7:0]          dataHi_q,    dataHi_d;
  logic [ADDR_W-1:0]   memAddr_q,   memAddr_d;
  logic [DATA_W-1:0]   memWdata_q,  memWdata_d;
  logic                weInstr_q,   weInstr_d;
  logic                weData_q,    weData_d;
  logic [15:0]         words_q,     words_d;

  logic ready;
  logic accept;

  // Terminal states stop the stream so no byte is ever consumed after end-of-load or an error.
  assign ready  = (state_q != DONE) && (state_q != ERR);
  assign accept = bus.in_valid && ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      toInstr_q  <= 1'b0;
      addrHi_q   <= '0;
      addr_q     <= '0;
      cntHi_q    <= '0;
      cnt_q      <= '0;
      dataHi_q   <= '0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      weInstr_q  <= 1'b0;
      weData_q   <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      toInstr_q  <= toInstr_d;
      addrHi_q   <= addrHi_d;
      addr_q     <= addr_d;
      cntHi_q    <= cntHi_d;
      cnt_q      <= cnt_d;
      dataHi_q   <= dataHi_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      weInstr_q  <= weInstr_d;
      weData_q   <= weData_d;
      words_q    <= words_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    toInstr_d  = toInstr_q;
    addrHi_d   = addrHi_q;
    addr_d     = addr_q;
    cntHi_d    = cntHi_q;
    cnt_d      = cnt_q;
    dataHi_d   = dataHi_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    weInstr_d  = 1'b0;
    weData_d   = 1'b0;
    words_d    = words_q;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          unique case (bus.in_data)
            CMD_INSTR: begin
              toInstr_d = 1'b1;
              state_d   = ADDR_H;
            end
            CMD_DATA: begin
              toInstr_d = 1'b0;
              state_d   = ADDR_H;
            end
            CMD_END: state_d = DONE;
            default: state_d = ERR;
          endcase
        end
        ADDR_H: begin
          addrHi_d = bus.in_data;
          state_d  = ADDR_L;
        end
        ADDR_L: begin
          // Upper address bits beyond the memory width are dropped by the size cast.
          addr_d  = ADDR_W'({addrHi_q, bus.in_data});
          state_d = CNT_H;
        end
        CNT_H: begin
          cntHi_d = bus.in_data;
          state_d = CNT_L;
        end
        CNT_L: begin
          cnt_d   = {cntHi_q, bus.in_data};
          state_d = ({cntHi_q, bus.in_data} == 16'd0) ? IDLE : DATA_H;
        end
        DATA_H: begin
          dataHi_d = bus.in_data;
          state_d  = DATA_L;
        end
        DATA_L: begin
          memAddr_d  = addr_q;
          memWdata_d = {dataHi_q, bus.in_data};
          weInstr_d  = toInstr_q;
          weData_d   = !toInstr_q;
          words_d    = words_q + 16'd1;
          addr_d     = addr_q + ADDR_W'(1);
          cnt_d      = cnt_q - 16'd1;
          state_d    = (cnt_q == 16'd1) ? IDLE : DATA_H;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.in_ready     = ready;
  assign bus.mem_addr     = memAddr_q;
  assign bus.mem_wdata    = memWdata_q;
  assign bus.mem_we_instr = weInstr_q;
  assign bus.mem_we_data  = weData_q;
  assign words_written    = words_q;
  assign dsp_run          = (state_q == DONE);
  assign err              = (state_q == ERR);

endmodule

// File: tb/tb_dsp_mem_loader.sv
// Directed bench for dsp_mem_loader: one task per scenario, expected values worked out by hand.
module tb_dsp_mem_loader;

  logic        clk;
  logic        reset;
  logic [15:0] wordsWritten;
  logic        dspRun;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  typedef struct {
    logic        isInstr;
    logic [11:0] addr;
    logic [15:0] data;
    int          cycle;
  } wr_t;

  wr_t writes[$];

  dsp_mem_loader_if #(.ADDR_W(12)) bus ();

  dsp_mem_loader #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .words_written (wordsWritten),
    .dsp_run       (dspRun),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every strobe a little after the edge that raised it.
  always @(posedge clk) begin
    cycleCount++;
    #1;
    if (bus.mem_we_instr || bus.mem_we_data) begin
      writes.push_back('{bus.mem_we_instr, bus.mem_addr, bus.mem_wdata, cycleCount});
      checks++;
      if ((bus.mem_we_instr && bus.mem_we_data) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dual_strobe: instr=%0b data=%0b, required at most one", bus.mem_we_instr, bus.mem_we_data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one byte for one cycle (called at a negedge), then optionally idles with junk data.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hF0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hF0;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyReset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
    writes.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_we_instr, bus.mem_we_data, wordsWritten, dspRun, err, bus.in_ready}
        !== {12'h000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_values: addr=%h wdata=%h wi=%b wd=%b ww=%0d run=%b err=%b rdy=%b, required all 0 and rdy=1",
               bus.mem_addr, bus.mem_wdata, bus.mem_we_instr, bus.mem_we_data, wordsWritten, dspRun, err, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    writes.delete();
  endtask

  task automatic test_instr_load();
    logic [7:0] hdr[5] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02};
    applyReset(1);
    foreach (hdr[i]) applyStimulus(hdr[i], 0);
    applyStimulus(8'h12, 0);
    applyStimulus(8'h34, 0);
    checks++;
    if ({bus.mem_we_instr, bus.mem_we_data, bus.mem_addr, bus.mem_wdata, wordsWritten} !== {1'b1, 1'b0, 12'h010, 16'h1234, 16'd1}) begin
      errors++;
      $display("[TB] FAIL instr_word0: wi=%b wd=%b addr=%h data=%h ww=%0d, required 1 0 010 1234 1",
               bus.mem_we_instr, bus.mem_we_data, bus.mem_addr, bus.mem_wdata, wordsWritten);
    end
    applyStimulus(8'hAB, 0);
    checks++;
    if ({bus.mem_we_instr, bus.mem_addr, bus.mem_wdata} !== {1'b0, 12'h010, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL instr_hold: wi=%b addr=%h data=%h, required 0 010 1234", bus.mem_we_instr, bus.mem_addr, bus.mem_wdata);
    end
    applyStimulus(8'hCD, 0);
    checks++;
    if ({bus.mem_we_instr, bus.mem_we_data, bus.mem_addr, bus.mem_wdata, wordsWritten} !== {1'b1, 1'b0, 12'h011, 16'hABCD, 16'd2}) begin
      errors++;
      $display("[TB] FAIL instr_word1: wi=%b wd=%b addr=%h data=%h ww=%0d, required 1 0 011 abcd 2",
               bus.mem_we_instr, bus.mem_we_data, bus.mem_addr, bus.mem_wdata, wordsWritten);
    end
    idle(3);
    checks++;
    if (writes.size() != 2 || writes[writes.size()-1].cycle - writes[0].cycle != 2 || !writes[0].isInstr) begin
      errors++;
      $display("[TB] FAIL instr_strobe_count: strobes=%0d, required 2 instr strobes 2 cycles apart", writes.size());
    end
  endtask

  task automatic test_data_load_stall();
    logic [7:0] hdr[5] = '{8'h5A, 8'h0F, 8'hFF, 8'h00, 8'h02};
    applyReset(1);
    foreach (hdr[i]) applyStimulus(hdr[i], 3);
    applyStimulus(8'h00, 3);
    applyStimulus(8'h01, 0);
    checks++;
    if ({bus.mem_we_data, bus.mem_we_instr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 12'hFFF, 16'h0001}) begin
      errors++;
      $display("[TB] FAIL data_word0: wd=%b wi=%b addr=%h data=%h, required 1 0 fff 0001",
               bus.mem_we_data, bus.mem_we_instr, bus.mem_addr, bus.mem_wdata);
    end
    idle(3);
    applyStimulus(8'h00, 3);
    applyStimulus(8'h02, 0);
    checks++;
    if ({bus.mem_we_data, bus.mem_addr, bus.mem_wdata, wordsWritten} !== {1'b1, 12'h000, 16'h0002, 16'd2}) begin
      errors++;
      $display("[TB] FAIL data_wrap: wd=%b addr=%h data=%h ww=%0d, required 1 000 0002 2",
               bus.mem_we_data, bus.mem_addr, bus.mem_wdata, wordsWritten);
    end
    idle(4);
    checks++;
    if (writes.size() != 2 || writes[0].isInstr || dspRun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL data_strobe_count: strobes=%0d run=%b, required 2 data strobes and run=0", writes.size(), dspRun);
    end
  endtask

  task automatic test_addr_mask();
    logic [7:0] seq[7] = '{8'hA5, 8'hF1, 8'h23, 8'h00, 8'h01, 8'hCA, 8'hFE};
    applyReset(1);
    foreach (seq[i]) applyStimulus(seq[i], 0);
    checks++;
    if ({bus.mem_we_instr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 12'h123, 16'hCAFE}) begin
      errors++;
      $display("[TB] FAIL addr_mask: wi=%b addr=%h data=%h, required 1 123 cafe", bus.mem_we_instr, bus.mem_addr, bus.mem_wdata);
    end
    idle(2);
  endtask

  task automatic test_zero_count_run();
    logic [7:0] hdr[5]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] post[7] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22};
    applyReset(1);
    foreach (hdr[i]) applyStimulus(hdr[i], 0);
    checks++;
    if ({dspRun, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL zero_cnt_pre_run: run=%b rdy=%b, required 0 1", dspRun, bus.in_ready);
    end
    applyStimulus(8'hF0, 0);
    checks++;
    if ({dspRun, bus.in_ready, err} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL run_raise: run=%b rdy=%b err=%b, required 1 0 0", dspRun, bus.in_ready, err);
    end
    foreach (post[i]) applyStimulus(post[i], 0);
    idle(2);
    checks++;
    if (writes.size() != 0 || wordsWritten !== 16'd0 || dspRun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_ignores_bytes: strobes=%0d ww=%0d run=%b, required 0 0 1", writes.size(), wordsWritten, dspRun);
    end
  endtask

  task automatic test_illegal_cmd();
    logic [7:0] post[7] = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'h33, 8'h44};
    applyReset(1);
    applyStimulus(8'h77, 0);
    checks++;
    if ({err, bus.in_ready, dspRun} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL illegal_cmd: err=%b rdy=%b run=%b, required 1 0 0", err, bus.in_ready, dspRun);
    end
    foreach (post[i]) applyStimulus(post[i], 0);
    idle(2);
    checks++;
    if (writes.size() != 0 || wordsWritten !== 16'd0 || dspRun !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: strobes=%0d ww=%0d run=%b err=%b, required 0 0 0 1", writes.size(), wordsWritten, dspRun, err);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] part[6] = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h12};
    logic [7:0] full[7] = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h56, 8'h78};
    applyReset(1);
    foreach (part[i]) applyStimulus(part[i], 0);
    bus.in_valid = 1'b0;
    applyReset(2);
    foreach (full[i]) applyStimulus(full[i], 0);
    idle(3);
    checks++;
    if (writes.size() != 1 || wordsWritten !== 16'd1) begin
      errors++;
      $display("[TB] FAIL reset_mid_word_count: strobes=%0d ww=%0d, required 1 1", writes.size(), wordsWritten);
    end else begin
      checks++;
      if ({writes[0].isInstr, writes[0].addr, writes[0].data} !== {1'b1, 12'h020, 16'h5678}) begin
        errors++;
        $display("[TB] FAIL reset_mid_word_data: instr=%b addr=%h data=%h, required 1 020 5678",
                 writes[0].isInstr, writes[0].addr, writes[0].data);
      end
    end
  endtask

  task automatic test_reset_cancel_strobe();
    logic [7:0] seq[7] = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'hAA, 8'hBB};
    applyReset(1);
    foreach (seq[i]) applyStimulus(seq[i], 0);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_we_instr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cancel_pre: wi=%b, required 1", bus.mem_we_instr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.mem_we_instr, bus.mem_we_data, bus.mem_addr, bus.mem_wdata, wordsWritten, bus.in_ready}
        !== {1'b0, 1'b0, 12'h000, 16'h0000, 16'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL cancel_strobe: wi=%b wd=%b addr=%h data=%h ww=%0d rdy=%b, required 0 0 000 0000 0 1",
               bus.mem_we_instr, bus.mem_we_data, bus.mem_addr, bus.mem_wdata, wordsWritten, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(1);
  endtask

  initial begin
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_instr_load();
    test_data_load_stall();
    test_addr_mask();
    test_zero_count_run();
    test_illegal_cmd();
    test_reset_mid_word();
    test_reset_cancel_strobe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
